instr_issue_queue: RTL and testbench
====================================

# instr_issue_queue

Buffers 12-bit machine codes from a host and issues them one at a time to the `processor` datapath. Drives the processor's `start`/`machine_code` inputs and waits for its `done` before retiring each entry. This makes the processor a queued execution resource, so the host can push a short program without tracking per-instruction completion. Sits between the host/test harness and the `processor` top.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `TIMEOUT`, 32: cycles in RUN without `done` before abort. Used only with `ISSUE_TIMEOUT_EN`; range 2..255.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `clock`.
- `push`  in  1  enqueue request, one entry per cycle.
- `push_code`  in  12  machine code to enqueue.
- `full`  out  1  `count == DEPTH`.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `overflow`  out  1  sticky; a push was dropped.
- `start`  out  1  to processor `start`; level, high for the whole RUN state.
- `machine_code`  out  12  to processor; head entry when `count > 0`, else 0.
- `done`  in  1  from processor; instruction complete.
- `busy`  out  1  state != IDLE.
- `retired`  out  8  instructions retired, including aborts; wraps 255 -> 0.
- `timeout`  out  1  sticky abort flag; tied 0 without `ISSUE_TIMEOUT_EN`.

## Operation
- Circular FIFO with read/write pointers and an occupancy counter.
- Push: `push=1` and `full=0` writes `push_code` at the tail and increments `count`.
- Dropped push: `push=1` and `full=1` writes nothing and sets `overflow`. `full` is evaluated before any same-cycle pop, so a push on a full queue is dropped even when a pop happens in that cycle.
- Simultaneous push (not full) and pop: `count` is unchanged and both pointers advance.
- FSM states:
  - IDLE: `start=0`. If `count > 0`, go to RUN next edge.
  - RUN: `start=1`; `machine_code` holds the head entry. On `done=1`, pop the head, increment `retired`, and go to RETIRE.
  - RETIRE: `start=0` for exactly one cycle, giving the processor step counter a deassert cycle; then go to IDLE.
- `done` is ignored in IDLE and RETIRE.
- The head entry cannot change during RUN, so `machine_code` is stable for the whole RUN interval.
- `reset=0` at any edge, including mid-RUN, empties the queue and forces IDLE.
  - Cleared to 0: `count`, `start`, `busy`, `overflow`, `timeout`, `retired`, `machine_code`.
  - `full` is 0 after reset.
  - The in-flight instruction is discarded, not retired.

## Timing
- Push at edge E (queue empty, IDLE): `count=1` after E; FSM enters RUN at E+1; `start` and `machine_code` are valid after E+1.
- `done` sampled high at edge D: `start` drops after D; `count` decrements after D; `retired` increments after D.
- Back-to-back instructions: the next RUN begins 2 edges after D (RETIRE, then IDLE), so `start` is low for 2 cycles between instructions.
- Minimum instruction interval: 3 cycles when `done` arrives in the first RUN cycle.
- All outputs are registered or decoded directly from registered state; there is no combinational path from `done` or `push` to any output.

## Configuration
- `ISSUE_TIMEOUT_EN` defined:
  - A RUN-cycle counter clears on entry to RUN.
  - If `TIMEOUT` RUN cycles elapse with `done=0`, the FSM pops the head, sets `timeout`, increments `retired`, and enters RETIRE.
  - If `done=1` arrives in the same cycle the timeout expires, it is a normal retire and `timeout` is not set.
- `ISSUE_TIMEOUT_EN` undefined: RUN waits indefinitely; `timeout` is constant 0; no counter logic is present.

## Test plan
- Reset sequencing: hold `reset=0` 2 cycles, then 1 -> all outputs 0, `busy=0`, `full=0`.
- Single issue: push 0x2C5 at edge 0, assert `done` in the 3rd RUN cycle -> `start`=1 after edge 1 for 3 cycles, `machine_code`=0x2C5 throughout, then `retired`=1, `count`=0, `busy`=0 two cycles later.
- Fill and overflow (`DEPTH`=4): push 0x001..0x005 on consecutive cycles with `done` held 0 -> `count`=4, `full`=1, `overflow`=1, 0x005 is never issued; the `machine_code` order observed is 0x001, 0x002, 0x003, 0x004.
- Concurrent push/pop: with `count`=2, push in the same cycle `done` retires the head -> `count` stays 2; the next issued code is the former second entry.
- Reset mid-RUN: 3 entries queued, `reset=0` during RUN -> `start`=0 next cycle, `count`=0, `retired` unchanged at 0, and a later `done` has no effect.
- Timeout (macro on, `TIMEOUT`=4): push 0x1FF, never assert `done` -> `start` high exactly 4 cycles, then `timeout`=1, `retired`=1, `count`=0. Same stimulus with the macro off -> `start` stays high indefinitely and `timeout`=0.

Source files
------------

// File: rtl/instr_issue_queue.sv
// instr_issue_queue: buffers 12-bit machine codes and issues them one at a time
// to the processor through a start/done handshake.
// Optional feature macro: ISSUE_TIMEOUT_EN aborts an instruction after TIMEOUT
// RUN cycles without done.
module instr_issue_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [11:0]              push_code,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     start,
  output logic [11:0]              machine_code,
  input  logic                     done,
  output logic                     busy,
  output logic [7:0]               retired,
  output logic                     timeout
);

  localparam int unsigned CODE_W = 12;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned RET_W  = 8;

  // Elaboration-time parameter sanity
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_issue_queue: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("instr_issue_queue: TIMEOUT must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RETIRE = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [CODE_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic                push_ok_c;
  logic                pop_c;
  logic                expire_c;
  logic [CNT_W-1:0]    count_n;

  assign full         = (count == CNT_W'(DEPTH));
  assign push_ok_c    = push && !full;
  assign count_n      = count + CNT_W'(push_ok_c) - CNT_W'(pop_c);
  assign start        = (state == RUN);
  assign busy         = (state != IDLE);
  assign machine_code = (count != '0) ? mem[rd_ptr] : '0;

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next state and pop decision
  always_comb begin
    state_n = state;
    pop_c   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) state_n = RUN;
      end
      RUN: begin
        if (done || expire_c) begin
          pop_c   = 1'b1;
          state_n = RETIRE;
        end
      end
      RETIRE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Queue storage; no reset needed since count gates visibility
  always_ff @(posedge clock) begin
    if (push_ok_c) mem[wr_ptr] <= push_code;
  end

  // Pointers, occupancy, sticky overflow and retire counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      retired  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        retired <= retired + RET_W'(1);
      end
      if (push && full) overflow <= 1'b1;
      count <= count_n;
    end
  end

`ifdef ISSUE_TIMEOUT_EN
  logic [7:0] run_cnt;
  logic       abort_c;

  // done wins over a same-cycle expiry, so abort only when done is low
  assign expire_c = (run_cnt == 8'(TIMEOUT - 1));
  assign abort_c  = (state == RUN) && !done && expire_c;

  // RUN-cycle counter (zero on RUN entry) and sticky timeout flag
  always_ff @(posedge clock) begin
    if (!reset) begin
      run_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      if (state != RUN) run_cnt <= '0;
      else              run_cnt <= run_cnt + 8'(1);
      if (abort_c) timeout <= 1'b1;
    end
  end
`else
  assign expire_c = 1'b0;
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Self-checking bench for instr_issue_queue: queue-based reference model,
// per-cycle compare, directed scenarios and randomized traffic.
module tb_instr_issue_queue;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0;
  logic [11:0] push_code = '0;
  logic        done = 1'b0;
  logic        full;
  logic [2:0]  count;
  logic        overflow;
  logic        start;
  logic [11:0] machine_code;
  logic        busy;
  logic [7:0]  retired;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  instr_issue_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .push(push), .push_code(push_code),
    .full(full), .count(count), .overflow(overflow), .start(start),
    .machine_code(machine_code), .done(done), .busy(busy),
    .retired(retired), .timeout(timeout)
  );

  always #5 clock = ~clock;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a queue of pending codes plus where we are in issuing the head
  int q[$];
  bit m_valid = 0;
  bit m_run = 0;
  bit m_cool = 0;
  bit m_ovf = 0;
  bit m_to = 0;
  int m_runcyc = 0;
  int m_ret = 0;

  always @(posedge clock) begin : model
    bit pop;
    int sz;
    pop = 0;
    sz  = q.size();
    if (!reset) begin
      q.delete();
      m_valid = 1; m_run = 0; m_cool = 0; m_ovf = 0; m_to = 0;
      m_runcyc = 0; m_ret = 0;
    end else begin
      if (m_run) begin
        m_runcyc++;
        if (done) begin
          pop = 1; m_run = 0; m_cool = 1;
        end
`ifdef ISSUE_TIMEOUT_EN
        else if (m_runcyc == TIMEOUT) begin
          pop = 1; m_run = 0; m_cool = 1; m_to = 1;
        end
`endif
      end else if (m_cool) begin
        m_cool = 0;
      end else if (sz > 0) begin
        m_run = 1; m_runcyc = 0;
      end
      if (pop) begin
        void'(q.pop_front());
        m_ret = (m_ret + 1) % 256;
      end
      if (push) begin
        if (sz == DEPTH) m_ovf = 1;
        else q.push_back(int'(push_code));
      end
    end
  end

  // Compare every cycle once a reset edge has defined the state
  always @(negedge clock) begin
    if (m_valid) begin
      chk("count", int'(count), q.size());
      chk("full", int'(full), int'(q.size() == DEPTH));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("start", int'(start), int'(m_run));
      chk("busy", int'(busy), int'(m_run || m_cool));
      chk("machine_code", int'(machine_code), (q.size() > 0) ? q[0] : 0);
      chk("retired", int'(retired), m_ret);
      chk("timeout", int'(timeout), int'(m_to));
    end
  end

  int  issued[$];
  bit  prev_start = 0;

  task automatic drive(input bit p, input int c, input bit d, input bit r);
    push = p; push_code = 12'(c); done = d; reset = r;
    @(posedge clock);
    #1;
    if (start && !prev_start) issued.push_back(int'(machine_code));
    prev_start = start;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    issued.delete();
  endtask

  initial begin : stim
    int hi_cnt;
    int n;
    // Reset sequencing
    do_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_start", int'(start), 0);
    chk("rst_retired", int'(retired), 0);
    chk("rst_mc", int'(machine_code), 0);

    // Single issue, done in the third RUN cycle
    drive(1, 'h2C5, 0, 1);
    chk("si_count1", int'(count), 1);
    chk("si_start_e0", int'(start), 0);
    drive(0, 0, 0, 1);
    chk("si_start_e1", int'(start), 1);
    chk("si_mc_e1", int'(machine_code), 'h2C5);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk("si_start_e3", int'(start), 1);
    chk("si_mc_e3", int'(machine_code), 'h2C5);
    drive(0, 0, 1, 1);
    chk("si_start_done", int'(start), 0);
    chk("si_retired", int'(retired), 1);
    chk("si_count0", int'(count), 0);
    drive(0, 0, 0, 1);
    chk("si_busy", int'(busy), 0);

    // Fill and overflow
    do_reset();
    for (int i = 1; i <= 5; i++) drive(1, i, 0, 1);
    chk("fo_count", int'(count), 4);
    chk("fo_full", int'(full), 1);
    chk("fo_overflow", int'(overflow), 1);
    n = 0;
    while ((q.size() > 0 || m_run || m_cool) && n < 40) begin
      drive(0, 0, m_run, 1);
      n++;
    end
    chk("fo_drain_bound", int'(n < 40), 1);
    chk("fo_issued_n", issued.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("fo_order", (i < issued.size()) ? issued[i] : -1, i + 1);
    chk("fo_retired", int'(retired), 4);

    // Concurrent push and pop
    do_reset();
    drive(1, 'h0A1, 0, 1);
    drive(1, 'h0B2, 0, 1);
    chk("cp_running", int'(start), 1);
    drive(1, 'h0C3, 1, 1);
    chk("cp_count", int'(count), 2);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk("cp_start", int'(start), 1);
    chk("cp_next", int'(machine_code), 'h0B2);

    // Reset mid-RUN
    do_reset();
    drive(1, 'h111, 0, 1);
    drive(1, 'h222, 0, 1);
    drive(1, 'h333, 0, 1);
    chk("mr_run", int'(start), 1);
    drive(0, 0, 0, 0);
    chk("mr_start", int'(start), 0);
    chk("mr_count", int'(count), 0);
    chk("mr_retired", int'(retired), 0);
    drive(0, 0, 1, 1);
    chk("mr_done_ignored", int'(retired), 0);
    chk("mr_start2", int'(start), 0);

    // Timeout behaviour (or its absence)
    do_reset();
    drive(1, 'h1FF, 0, 1);
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1);
      if (start) hi_cnt++;
    end
`ifdef ISSUE_TIMEOUT_EN
    chk("to_hi_cycles", hi_cnt, 4);
    chk("to_flag", int'(timeout), 1);
    chk("to_retired", int'(retired), 1);
    chk("to_count", int'(count), 0);
`else
    chk("to_hi_cycles", hi_cnt, 8);
    chk("to_still_run", int'(start), 1);
    chk("to_flag", int'(timeout), 0);
    chk("to_count", int'(count), 1);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 9) < 4, int'($urandom_range(0, 4095)),
            $urandom_range(0, 9) < 3, $urandom_range(0, 149) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
